// File: rtl/scoreboard_param.sv
// Register scoreboard for the issue stage: per-register writeback countdown and
// producing-FU tracking, with WAW refusal, squash and operand hazard queries.

module scoreboard_entry #(
   parameter int FU_W  = 2,
   parameter int LAT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             kill,
   input  logic [LAT_W-1:0] load_lat,
   input  logic [FU_W-1:0]  load_fu,
   output logic [LAT_W-1:0] cnt,
   output logic [FU_W-1:0]  fu
);
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic [FU_W-1:0]  fu_q, fu_d;

   // An accepted issue beats a same-cycle kill of the same register.
   always_comb begin
      cnt_d = cnt_q;
      fu_d  = fu_q;
      if (load) begin
         cnt_d = load_lat;
         fu_d  = load_fu;
      end else if (kill) begin
         cnt_d = '0;
         fu_d  = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - LAT_W'(1);
         if (cnt_q == LAT_W'(1)) fu_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         fu_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         fu_q  <= fu_d;
      end
   end

   assign cnt = cnt_q;
   assign fu  = fu_q;
endmodule

module scoreboard_param #(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int FU_W     = 2,
   parameter int LAT_W    = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                issue_valid,
   input  logic [REG_AW-1:0]   issue_rd,
   input  logic [FU_W-1:0]     issue_fu,
   input  logic [LAT_W-1:0]    issue_lat,
   output logic                issue_stall,
   input  logic                kill_valid,
   input  logic [REG_AW-1:0]   kill_rd,
   input  logic [REG_AW-1:0]   rs_addr,
   input  logic [REG_AW-1:0]   rt_addr,
   output logic                rs_pending,
   output logic                rt_pending,
   output logic [FU_W-1:0]     rs_fu,
   output logic [FU_W-1:0]     rt_fu,
   output logic                rs_last,
   output logic                rt_last,
   output logic [NUM_REGS-1:0] pnd_sgn
);
   logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
   logic [NUM_REGS-1:0][FU_W-1:0]  fu;
   logic [LAT_W-1:0]               eff_lat;
   logic                           issue_acc;

   assign eff_lat     = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
   // Refuse only when the older write would land after the new one.
   assign issue_stall = issue_valid && (issue_rd != '0) && (cnt[issue_rd] > eff_lat);
   assign issue_acc   = issue_valid && !issue_stall && (issue_rd != '0);

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      if (r == 0) begin : g_zero
         assign cnt[r] = '0;
         assign fu[r]  = '0;
      end else begin : g_ent
         scoreboard_entry #(.FU_W(FU_W), .LAT_W(LAT_W)) u_ent (
            .clock    (clock),
            .reset    (reset),
            .load     (issue_acc && (issue_rd == REG_AW'(r))),
            .kill     (kill_valid && (kill_rd == REG_AW'(r))),
            .load_lat (eff_lat),
            .load_fu  (issue_fu),
            .cnt      (cnt[r]),
            .fu       (fu[r])
         );
      end
      assign pnd_sgn[r] = (cnt[r] != '0);
   end

   assign rs_pending = pnd_sgn[rs_addr];
   assign rs_fu      = fu[rs_addr];
   assign rs_last    = (cnt[rs_addr] == LAT_W'(1));
   assign rt_pending = pnd_sgn[rt_addr];
   assign rt_fu      = fu[rt_addr];
   assign rt_last    = (cnt[rt_addr] == LAT_W'(1));
endmodule
